// File: rtl/colscan_pkg.sv
// Shared definitions for collision_scan_mux: FSM state encodings and the
// MSB-first column-to-row-bit mapping used by the footprint scan.
package colscan_pkg;

  localparam logic [1:0] COLSCAN_IDLE = 2'd0;
  localparam logic [1:0] COLSCAN_SCAN = 2'd1;
  localparam logic [1:0] COLSCAN_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = COLSCAN_IDLE,
    ST_SCAN = COLSCAN_SCAN,
    ST_DONE = COLSCAN_DONE
  } colscan_state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] idx;
  } colscan_bit_t;

  // Column c maps to row bit (data_width-1-c); columns past the row read as invalid.
  function automatic colscan_bit_t colscan_col_to_bit(input logic [15:0] col,
                                                     input logic [15:0] data_width);
    colscan_bit_t r;
    r.valid = (col < data_width);
    r.idx   = r.valid ? (data_width - 16'd1 - col) : 16'd0;
    return r;
  endfunction

endpackage

// File: rtl/colscan_lane_select.sv
// Combinational extraction of one lane row from the flat lane bus.
// Lanes at or beyond NUM_LANES read as an all-zero row.
module colscan_lane_select #(
  parameter int NUM_LANES      = 8,
  parameter int DATAWIDTH_DATA = 16,
  parameter int DATAWIDTH_LANE = 3
) (
  input  logic [NUM_LANES*DATAWIDTH_DATA-1:0] i_data,
  input  logic [DATAWIDTH_LANE-1:0]           i_lane,
  output logic [DATAWIDTH_DATA-1:0]           o_row
);

  always_comb begin
    o_row = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (int'(i_lane) == l) o_row = i_data[l*DATAWIDTH_DATA +: DATAWIDTH_DATA];
    end
  end

endmodule

// File: rtl/collision_scan_mux.sv
// Sequenced collision sampler: captures one lane row on Start, scans the player
// footprint one column per cycle, reports a held result plus a sticky flag.
// Optional saturating hit counter is enabled by defining COLSCAN_HITCOUNT_EN.
module collision_scan_mux
  import colscan_pkg::*;
#(
  parameter int DATAWIDTH_SELECTOR = 4,
  parameter int DATAWIDTH_DATA     = 16,
  parameter int NUM_LANES          = 8,
  parameter int DATAWIDTH_LANE     = 3,
  parameter int FROG_WIDTH         = 2,
  parameter int HITCOUNT_WIDTH     = 8
) (
  input  logic                                Colscan_CLOCK_50,
  input  logic                                Colscan_RESET_InLow,
  input  logic                                Colscan_Start_Bit_In,
  input  logic [DATAWIDTH_LANE-1:0]           Colscan_Lane_Bus_In,
  input  logic [DATAWIDTH_SELECTOR-1:0]       Colscan_Column_Bus_In,
  input  logic [NUM_LANES*DATAWIDTH_DATA-1:0] Colscan_Data_Bus_In,
  input  logic                                Colscan_Clear_Bit_In,
  output logic                                Colscan_Busy_Bit_Out,
  output logic                                Colscan_Valid_Bit_Out,
  output logic                                Colscan_Z_Bit_Out,
  output logic                                Colscan_Sticky_Bit_Out,
`ifdef COLSCAN_HITCOUNT_EN
  output logic [HITCOUNT_WIDTH-1:0]           Colscan_HitCount_Bus_Out,
`endif
  output colscan_state_t                      o_dbg_state
);

  // Handshake: Start is sampled only while Busy is low; Valid pulses for exactly
  // one cycle per completed scan, with Z and Sticky already updated in that cycle.

  if (DATAWIDTH_DATA > (1 << DATAWIDTH_SELECTOR) || FROG_WIDTH < 1 || HITCOUNT_WIDTH < 1)
  begin : g_bad_params
    $error("collision_scan_mux: illegal parameter combination");
  end

  colscan_state_t              r_state;
  logic [DATAWIDTH_DATA-1:0]   r_row;
  logic [DATAWIDTH_SELECTOR-1:0] r_col;
  logic [15:0]                 r_offset;
  logic                        r_busy;
  logic                        r_valid;
  logic                        r_z;
  logic                        r_sticky;

  logic [DATAWIDTH_DATA-1:0]   w_lane_row;
  logic [15:0]                 w_col_sum;
  colscan_bit_t                w_bit;
  logic                        w_hit;
  logic                        w_last;
  logic                        w_scan_hit;
  logic                        w_set;

  colscan_lane_select #(
    .NUM_LANES      (NUM_LANES),
    .DATAWIDTH_DATA (DATAWIDTH_DATA),
    .DATAWIDTH_LANE (DATAWIDTH_LANE)
  ) u_lane_select (
    .i_data (Colscan_Data_Bus_In),
    .i_lane (Colscan_Lane_Bus_In),
    .o_row  (w_lane_row)
  );

  assign w_col_sum = 16'(r_col) + r_offset;
  assign w_bit     = colscan_col_to_bit(w_col_sum, 16'(DATAWIDTH_DATA));
  assign w_last    = (r_offset == 16'(FROG_WIDTH - 1));

  always_comb begin
    w_hit = 1'b0;
    for (int b = 0; b < DATAWIDTH_DATA; b++) begin
      if (w_bit.valid && int'(w_bit.idx) == b) w_hit = r_row[b];
    end
  end

  // A hit holds "set" both on the edge entering DONE and across the DONE cycle,
  // so a Clear landing in either cycle of a hitting scan loses to the hit.
  assign w_scan_hit = (r_state == ST_SCAN) && w_hit;
  assign w_set      = w_scan_hit || ((r_state == ST_DONE) && r_z);

  always_ff @(posedge Colscan_CLOCK_50) begin
    if (!Colscan_RESET_InLow) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_offset <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_z      <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Colscan_Start_Bit_In) begin
            r_row    <= w_lane_row;
            r_col    <= Colscan_Column_Bus_In;
            r_offset <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit || w_last) begin
            r_z     <= w_hit;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_offset <= r_offset + 16'd1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      if (w_set) r_sticky <= 1'b1;
      else if (Colscan_Clear_Bit_In) r_sticky <= 1'b0;
    end
  end

`ifdef COLSCAN_HITCOUNT_EN
  logic [HITCOUNT_WIDTH-1:0] r_hitcount;

  always_ff @(posedge Colscan_CLOCK_50) begin
    if (!Colscan_RESET_InLow) begin
      r_hitcount <= '0;
    end else if (w_scan_hit) begin
      if (Colscan_Clear_Bit_In)  r_hitcount <= HITCOUNT_WIDTH'(1);
      else if (r_hitcount != '1) r_hitcount <= r_hitcount + HITCOUNT_WIDTH'(1);
    end else if (Colscan_Clear_Bit_In) begin
      r_hitcount <= w_set ? HITCOUNT_WIDTH'(1) : '0;
    end
  end

  assign Colscan_HitCount_Bus_Out = r_hitcount;
`endif

  assign Colscan_Busy_Bit_Out   = r_busy;
  assign Colscan_Valid_Bit_Out  = r_valid;
  assign Colscan_Z_Bit_Out      = r_z;
  assign Colscan_Sticky_Bit_Out = r_sticky;
  assign o_dbg_state            = r_state;

endmodule

// File: doc/collision_scan_mux.md
# collision_scan_mux

Sequenced collision sampler for the game's COLISION path. It replaces single-row, single-bit 8:1 selection with a parametrised multi-lane row bitmap, a multi-column player footprint, a start/busy/valid handshake and a sticky collision flag. It sits between the lane/obstacle bitmap generators and the game-control FSM. On request it captures one lane row and scans the player's footprint one bit per cycle. It then reports a registered collision result.

## Interface
- DATAWIDTH_SELECTOR, 4, column index width
- DATAWIDTH_DATA, 16, bits per lane row; must be ≤ 2**DATAWIDTH_SELECTOR
- NUM_LANES, 8, number of lane rows
- DATAWIDTH_LANE, 3, lane index width
- FROG_WIDTH, 2, footprint width in columns, ≥1
- HITCOUNT_WIDTH, 8, hit counter width (macro-dependent)

Ports:
- Colscan_CLOCK_50  in  1  sole clock, rising edge
- Colscan_RESET_InLow  in  1  reset, synchronous, active-low
- Colscan_Start_Bit_In  in  1  sample request, sampled only in IDLE
- Colscan_Lane_Bus_In  in  DATAWIDTH_LANE  lane to test
- Colscan_Column_Bus_In  in  DATAWIDTH_SELECTOR  leftmost footprint column
- Colscan_Data_Bus_In  in  NUM_LANES*DATAWIDTH_DATA  lane rows; lane L occupies bits [L*DATAWIDTH_DATA +: DATAWIDTH_DATA]
- Colscan_Clear_Bit_In  in  1  clears sticky flag
- Colscan_Busy_Bit_Out  out  1  high while not IDLE
- Colscan_Valid_Bit_Out  out  1  one-cycle result strobe
- Colscan_Z_Bit_Out  out  1  result of last completed scan, held
- Colscan_Sticky_Bit_Out  out  1  OR of all results since last clear/reset
- Colscan_HitCount_Bus_Out  out  HITCOUNT_WIDTH  saturating hit count (only with macro)

## Operation
- Column mapping is MSB-first: column c tests row bit DATAWIDTH_DATA-1-c.
- Footprint columns are c, c+1, …, c+FROG_WIDTH-1.
- Any column ≥ DATAWIDTH_DATA, or lane ≥ NUM_LANES, reads as 0.
- FSM states:
  - IDLE: on Start=1, register the lane row slice, column and offset=0, then go to SCAN.
  - SCAN: test bit at column+offset.
    - On a hit, set result=1 and go to DONE.
    - On no hit with offset=FROG_WIDTH-1, set result=0 and go to DONE.
    - Otherwise increment offset and stay in SCAN.
  - DONE: Valid=1. Z updates to result at entry. Sticky |= result. Go to IDLE.
- The row is captured at the start edge. Data changes during a scan are ignored.
- Start while Busy=1 is ignored and not queued.
- Clear and a DONE hit in the same cycle: set wins, so Sticky=1.
- Clear in any other case: Sticky=0 next cycle.
- Reset: state IDLE; Busy, Valid, Z, Sticky and HitCount all 0.
- Reset mid-scan aborts the scan; no Valid is produced.

## Timing
- Start high in cycle 0 (IDLE) → SCAN occupies cycles 1..k, where k = number of bits tested, 1..FROG_WIDTH (early exit on hit).
- Valid is high in cycle k+1. Busy is high in cycles 1..k+1.
- A new Start is accepted at cycle k+2 at the earliest.
- Z and Sticky change at the edge entering DONE and are visible together with Valid.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- COLSCAN_HITCOUNT_EN defined:
  - Colscan_HitCount_Bus_Out exists.
  - It increments by 1 on each DONE with result=1 and saturates at 2**HITCOUNT_WIDTH-1.
  - Clear also zeroes it; set wins on a simultaneous hit, giving a value of 1.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared package colscan_pkg holds:
  - state localparams (IDLE=2'd0, SCAN=2'd1, DONE=2'd2)
  - column-to-bit-index function (MSB-first with out-of-range → invalid)
- One sub-module, colscan_lane_select: combinational lane slice extraction from the flat data bus, with out-of-range lane → all zeros.

## Test plan
Defaults are used unless a scenario states otherwise.
- Lane 3 row=16'h8000, column 0, Start at cycle 0 → Valid at cycle 2 (k=1), Z=1, Sticky=1.
- Lane 2 row=16'h4000, column 0 → bit15=0, bit14=1 → Valid at cycle 3, Z=1.
- Lane 5 row=16'h0001, column 15 → hit on bit0 at offset 0, Valid at cycle 2. Repeat with row=16'h0000 → offset 1 is out of range, Valid at cycle 3, Z=0, Sticky unchanged.
- Start pulsed in cycles 1 and 2 of a scan → ignored, exactly one Valid. Clear asserted in the DONE cycle of a hit → Sticky stays 1. Clear asserted alone later → Sticky=0.
- Reset low for one cycle during SCAN → next cycle Busy=0, Valid never asserts, Z=0, Sticky=0.
- With COLSCAN_HITCOUNT_EN and HITCOUNT_WIDTH=2, run 5 hitting scans → count 1,2,3,3,3. Clear → 0.
